// File: rtl/wb_arbiter_pkg.sv
// Shared widths, protected register indices and source encoding for the
// writeback arbiter and its FIFOs.
package wb_arbiter_pkg;

    localparam int DATA_W         = 64;
    localparam int ADDR_W         = 8;
    localparam int NUM_REGS       = 100;
    localparam int DEF_FIFO_DEPTH = 4;

    localparam logic [ADDR_W-1:0] REG_ZERO   = 8'd0;
    localparam logic [ADDR_W-1:0] REG_CONST  = 8'd1;
    localparam logic [ADDR_W:0]   NUM_REGS_C = (ADDR_W+1)'(NUM_REGS);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    // Writes to the hardwired registers or past the last implemented one are dropped.
    function automatic logic is_writable_rd(input logic [ADDR_W-1:0] rd);
        return (rd != REG_ZERO) && (rd != REG_CONST) && ({1'b0, rd} < NUM_REGS_C);
    endfunction

endpackage

// File: rtl/wb_arbiter_fifo.sv
// Synchronous FIFO with registered full/empty flags and a first-word
// fall-through head; depth must be a power of two.
module wb_fifo #(
    parameter int WIDTH = 72,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push && !full_r;
    assign pop_ok_s  = pop && !empty_r;
    assign head_data = mem_r[rd_ptr_r];
    assign full      = full_r;
    assign empty     = empty_r;
    assign count     = count_r;

    // Occupancy after this edge, used to register the flags.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy and flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_MAX);
            empty_r <= (count_nxt_s == {CW{1'b0}});
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers ALU and load results, picks one per cycle with
// round-robin on ties, and filters writes to protected or absent registers.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              reg_write_cmd,
    output logic [ADDR_W-1:0] reg_write,
    output logic [DATA_W-1:0] reg_write_data,
    output logic [15:0]       drop_count,
    output logic              idle
);

    localparam int EW = ADDR_W + DATA_W;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic              alu_push_s;
    logic              mem_push_s;
    logic              alu_pop_s;
    logic              mem_pop_s;
    logic [EW-1:0]     alu_head_s;
    logic [EW-1:0]     mem_head_s;
    logic [EW-1:0]     sel_head_s;
    logic              alu_full_s;
    logic              mem_full_s;
    logic              alu_empty_s;
    logic              mem_empty_s;
    logic [CW-1:0]     alu_count_s;
    logic [CW-1:0]     mem_count_s;
    logic              pop_s;
    logic              tie_s;
    logic              writable_s;
    src_e              grant_s;
    src_e              last_grant_r;
    logic              cmd_r;
    logic [ADDR_W-1:0] rd_r;
    logic [DATA_W-1:0] data_r;
    logic [15:0]       drop_r;

    assign alu_ready  = !alu_full_s;
    assign mem_ready  = !mem_full_s;
    assign alu_push_s = alu_valid && !alu_full_s;
    assign mem_push_s = mem_valid && !mem_full_s;

    wb_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (alu_push_s),
        .push_data ({alu_rd, alu_data}),
        .pop       (alu_pop_s),
        .head_data (alu_head_s),
        .full      (alu_full_s),
        .empty     (alu_empty_s),
        .count     (alu_count_s)
    );

    wb_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_mem_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (mem_push_s),
        .push_data ({mem_rd, mem_data}),
        .pop       (mem_pop_s),
        .head_data (mem_head_s),
        .full      (mem_full_s),
        .empty     (mem_empty_s),
        .count     (mem_count_s)
    );

    // Grant selection; only a tie consults the round-robin pointer.
    always_comb begin
        pop_s   = 1'b0;
        tie_s   = 1'b0;
        grant_s = SRC_ALU;
        case ({!alu_empty_s, !mem_empty_s})
            2'b10: begin
                pop_s   = 1'b1;
                grant_s = SRC_ALU;
            end
            2'b01: begin
                pop_s   = 1'b1;
                grant_s = SRC_MEM;
            end
            2'b11: begin
                pop_s   = 1'b1;
                tie_s   = 1'b1;
                grant_s = (last_grant_r == SRC_ALU) ? SRC_MEM : SRC_ALU;
            end
            default: begin
                pop_s   = 1'b0;
                tie_s   = 1'b0;
                grant_s = SRC_ALU;
            end
        endcase
    end

    assign alu_pop_s = pop_s && (grant_s == SRC_ALU);
    assign mem_pop_s = pop_s && (grant_s == SRC_MEM);

    // Head of the granted FIFO.
    always_comb begin
        sel_head_s = alu_head_s;
        case (grant_s)
            SRC_ALU: sel_head_s = alu_head_s;
            SRC_MEM: sel_head_s = mem_head_s;
            default: sel_head_s = alu_head_s;
        endcase
    end

    assign writable_s = is_writable_rd(sel_head_s[EW-1:DATA_W]);

    // Round-robin pointer, updated only when both sources competed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant_r <= SRC_ALU;
        end else if (tie_s) begin
            last_grant_r <= grant_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Register-file port: index/data hold between pops, strobe is one cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cmd_r  <= 1'b0;
            rd_r   <= {ADDR_W{1'b0}};
            data_r <= {DATA_W{1'b0}};
        end else if (pop_s) begin
            cmd_r  <= writable_s;
            rd_r   <= sel_head_s[EW-1:DATA_W];
            data_r <= sel_head_s[DATA_W-1:0];
        end else begin
            cmd_r  <= 1'b0;
        end
    end

    // Saturating count of filtered writes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            drop_r <= 16'd0;
        end else if (pop_s && !writable_s && (drop_r != 16'hFFFF)) begin
            drop_r <= drop_r + 16'd1;
        end else begin
            drop_r <= drop_r;
        end
    end

    assign reg_write_cmd  = cmd_r;
    assign reg_write      = rd_r;
    assign reg_write_data = data_r;
    assign drop_count     = drop_r;
    assign idle           = (alu_count_s == {CW{1'b0}}) && (mem_count_s == {CW{1'b0}}) && !cmd_r;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a vector table for the steady-state flow,
// then reset-mid-stream, backpressure and drop-counter saturation sequences.
module tb_wb_arbiter;

    logic        clock;
    logic        reset;
    logic        alu_valid;
    logic        alu_ready;
    logic [7:0]  alu_rd;
    logic [63:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [7:0]  mem_rd;
    logic [63:0] mem_data;
    logic        reg_write_cmd;
    logic [7:0]  reg_write;
    logic [63:0] reg_write_data;
    logic [15:0] drop_count;
    logic        idle;

    int n_cmp;
    int n_mis;

    localparam logic [63:0] DBASE = 64'hC0DE_0000_0000_0000;

    typedef struct {
        logic        av;
        logic [7:0]  ard;
        logic [63:0] adat;
        logic        mv;
        logic [7:0]  mrd;
        logic [63:0] mdat;
        logic        ecmd;
        logic [7:0]  erd;
        logic [63:0] edat;
        logic [15:0] edrop;
        logic        eidle;
    } vec_t;

    vec_t tbl [14];
    int   exp_bp [15];

    wb_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_rd         (alu_rd),
        .alu_data       (alu_data),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_rd         (mem_rd),
        .mem_data       (mem_data),
        .reg_write_cmd  (reg_write_cmd),
        .reg_write      (reg_write),
        .reg_write_data (reg_write_data),
        .drop_count     (drop_count),
        .idle           (idle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic av, input logic [7:0] ard, input logic [63:0] adat,
                                input logic mv, input logic [7:0] mrd, input logic [63:0] mdat,
                                input logic ecmd, input logic [7:0] erd, input logic [63:0] edat,
                                input logic [15:0] edrop, input logic eidle);
        vec_t v;
        v.av = av;   v.ard = ard;   v.adat = adat;
        v.mv = mv;   v.mrd = mrd;   v.mdat = mdat;
        v.ecmd = ecmd; v.erd = erd; v.edat = edat;
        v.edrop = edrop; v.eidle = eidle;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = 8'd0; alu_data = 64'd0;
        mem_valid = 1'b0; mem_rd = 8'd0; mem_data = 64'd0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".cmd"},   {63'd0, reg_write_cmd}, 64'd0);
        chk({tag, ".rd"},    {56'd0, reg_write},     64'd0);
        chk({tag, ".data"},  reg_write_data,         64'd0);
        chk({tag, ".drop"},  {48'd0, drop_count},    64'd0);
        chk({tag, ".idle"},  {63'd0, idle},          64'd1);
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        idle_inputs();
        reset = 1'b0;

        // rows: alu in, mem in, expected port state after the edge
        tbl[0]  = mk(1'b1, 8'd5,   64'hDEAD_BEEF, 1'b0, 8'd0, 64'h0,  1'b0, 8'd0,   64'h0,         16'd0, 1'b0);
        tbl[1]  = mk(1'b0, 8'd0,   64'h0,         1'b0, 8'd0, 64'h0,  1'b1, 8'd5,   64'hDEAD_BEEF, 16'd0, 1'b0);
        tbl[2]  = mk(1'b0, 8'd0,   64'h0,         1'b0, 8'd0, 64'h0,  1'b0, 8'd5,   64'hDEAD_BEEF, 16'd0, 1'b1);
        tbl[3]  = mk(1'b1, 8'd3,   64'hA3,        1'b1, 8'd4, 64'hB4, 1'b0, 8'd5,   64'hDEAD_BEEF, 16'd0, 1'b0);
        tbl[4]  = mk(1'b1, 8'd6,   64'hA6,        1'b1, 8'd7, 64'hB7, 1'b1, 8'd4,   64'hB4,        16'd0, 1'b0);
        tbl[5]  = mk(1'b0, 8'd0,   64'h0,         1'b0, 8'd0, 64'h0,  1'b1, 8'd3,   64'hA3,        16'd0, 1'b0);
        tbl[6]  = mk(1'b0, 8'd0,   64'h0,         1'b0, 8'd0, 64'h0,  1'b1, 8'd7,   64'hB7,        16'd0, 1'b0);
        tbl[7]  = mk(1'b0, 8'd0,   64'h0,         1'b0, 8'd0, 64'h0,  1'b1, 8'd6,   64'hA6,        16'd0, 1'b0);
        tbl[8]  = mk(1'b0, 8'd0,   64'h0,         1'b1, 8'd1, 64'h11, 1'b0, 8'd6,   64'hA6,        16'd0, 1'b0);
        tbl[9]  = mk(1'b1, 8'd100, 64'h22,        1'b0, 8'd0, 64'h0,  1'b0, 8'd1,   64'h11,        16'd1, 1'b0);
        tbl[10] = mk(1'b1, 8'd99,  64'h33,        1'b1, 8'd0, 64'h44, 1'b0, 8'd100, 64'h22,        16'd2, 1'b0);
        tbl[11] = mk(1'b0, 8'd0,   64'h0,         1'b0, 8'd0, 64'h0,  1'b1, 8'd99,  64'h33,        16'd2, 1'b0);
        tbl[12] = mk(1'b0, 8'd0,   64'h0,         1'b0, 8'd0, 64'h0,  1'b0, 8'd0,   64'h44,        16'd3, 1'b1);
        tbl[13] = mk(1'b0, 8'd0,   64'h0,         1'b0, 8'd0, 64'h0,  1'b0, 8'd0,   64'h44,        16'd3, 1'b1);

        exp_bp = '{-1, 20, 10, 21, 11, 22, 12, 23, 13, 24, 14, 25, 15, 26, -1};

        // Power-on reset
        step();
        step();
        check_reset_state("por");
        reset = 1'b1;
        step();
        check_reset_state("post_por");
        chk("post_por.alu_ready", {63'd0, alu_ready}, 64'd1);
        chk("post_por.mem_ready", {63'd0, mem_ready}, 64'd1);

        // Table-driven flow: single write, contention, filtering, last_grant retention
        for (int i = 0; i < 14; i++) begin
            alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].adat;
            mem_valid = tbl[i].mv; mem_rd = tbl[i].mrd; mem_data = tbl[i].mdat;
            step();
            chk($sformatf("row%0d.cmd", i),   {63'd0, reg_write_cmd}, {63'd0, tbl[i].ecmd});
            chk($sformatf("row%0d.rd", i),    {56'd0, reg_write},     {56'd0, tbl[i].erd});
            chk($sformatf("row%0d.data", i),  reg_write_data,         tbl[i].edat);
            chk($sformatf("row%0d.drop", i),  {48'd0, drop_count},    {48'd0, tbl[i].edrop});
            chk($sformatf("row%0d.idle", i),  {63'd0, idle},          {63'd0, tbl[i].eidle});
            chk($sformatf("row%0d.ardy", i),  {63'd0, alu_ready},     64'd1);
            chk($sformatf("row%0d.mrdy", i),  {63'd0, mem_ready},     64'd1);
        end
        idle_inputs();

        // Reset mid-stream with an entry still buffered
        for (int k = 0; k < 3; k++) begin
            alu_valid = 1'b1;
            alu_rd    = (k == 0) ? 8'd0 : 8'(7 + k);
            alu_data  = DBASE | 64'(k);
            step();
            if (k == 1) chk("mid.drop_before", {48'd0, drop_count}, 64'd4);
        end
        idle_inputs();
        chk("mid.cmd_before", {63'd0, reg_write_cmd}, 64'd1);
        chk("mid.rd_before",  {56'd0, reg_write},     64'd8);
        chk("mid.idle_before", {63'd0, idle},         64'd0);
        reset = 1'b0;
        #1;
        check_reset_state("mid_async");
        step();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("mid.flushed_cmd%0d", k), {63'd0, reg_write_cmd}, 64'd0);
            chk($sformatf("mid.flushed_rd%0d", k),  {56'd0, reg_write},     64'd0);
            chk($sformatf("mid.alu_ready%0d", k),   {63'd0, alu_ready},     64'd1);
        end

        // Backpressure: both sources push every cycle until ALU fills
        for (int k = 1; k <= 15; k++) begin
            if (k <= 7) begin
                alu_valid = 1'b1; alu_rd = 8'(9 + k);  alu_data = DBASE | 64'(9 + k);
                mem_valid = 1'b1; mem_rd = 8'(19 + k); mem_data = DBASE | 64'(19 + k);
            end else begin
                idle_inputs();
            end
            step();
            if (exp_bp[k-1] < 0) begin
                chk($sformatf("bp%0d.cmd", k), {63'd0, reg_write_cmd}, 64'd0);
            end else begin
                chk($sformatf("bp%0d.cmd", k),  {63'd0, reg_write_cmd}, 64'd1);
                chk($sformatf("bp%0d.rd", k),   {56'd0, reg_write},     64'(exp_bp[k-1]));
                chk($sformatf("bp%0d.data", k), reg_write_data,         DBASE | 64'(exp_bp[k-1]));
            end
            if (k == 6) chk("bp.alu_full", {63'd0, alu_ready}, 64'd0);
            if (k == 7) begin
                chk("bp.alu_reopen", {63'd0, alu_ready}, 64'd1);
                chk("bp.mem_full",   {63'd0, mem_ready}, 64'd0);
            end
        end
        chk("bp.idle_end", {63'd0, idle}, 64'd1);

        // Drop-counter saturation: one filtered write per cycle
        alu_valid = 1'b1; alu_rd = 8'd0; alu_data = 64'h5A;
        for (int k = 0; k < 65600; k++) begin
            step();
        end
        idle_inputs();
        step();
        step();
        chk("sat.drop",  {48'd0, drop_count},    64'hFFFF);
        chk("sat.cmd",   {63'd0, reg_write_cmd}, 64'd0);
        chk("sat.idle",  {63'd0, idle},          64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
